// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIVISOR/CTRL registers feeding an 8N1 serial frame.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (CTRL bit2 selects odd parity).
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  memType,
  input  logic [63:0] addr,
  input  logic [63:0] wd,
  output logic [63:0] rd,
  output logic        tx,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 2;
`endif

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } txState_t;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic [15:0]       divisor, frameDiv, baudCnt;
  logic [CTRL_W-1:0] ctrl;
  txState_t          state;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
`ifdef UART_TX_PARITY_EN
  logic              parityBit;
`endif

  logic [1:0]  regSel;
  logic        regWrite, pushReq, pushOk, pop;
  logic        fifoFull, fifoEmpty, busy;
  logic [15:0] sizeMask;
  logic [63:0] regVal, sized;

  assign regSel    = addr[4:3];
  assign regWrite  = sel & we;
  assign fifoFull  = (count == DEPTH_C);
  assign fifoEmpty = (count == '0);
  assign busy      = (state != IDLE);
  assign pushReq   = regWrite & (regSel == REG_TXDATA);
  // A byte leaves the FIFO when the line is free: idle, or the last clock of a stop bit.
  assign pop       = ctrl[0] & ~fifoEmpty &
                     ((state == IDLE) | ((state == STOP) & (baudCnt == 16'd0)));
  assign pushOk    = pushReq & (~fifoFull | pop);
  assign irq       = ctrl[1] & fifoEmpty & (state == IDLE);

  // NOTE: storage is not reset; only pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= wd[7:0];
  end

  // NOTE: non-blocking assignments so every register reacts to pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      divisor <= DIV_RESET;
      ctrl    <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (pushReq & fifoFull & ~pop)
        ovf <= 1'b1;
      else if (regWrite & (regSel == REG_STATUS))
        ovf <= 1'b0;
      if (regWrite & (regSel == REG_DIVISOR))
        divisor <= (divisor & ~sizeMask) | (wd[15:0] & sizeMask);
      // Every access size covers the low byte, so CTRL always takes all its bits.
      if (regWrite & (regSel == REG_CTRL))
        ctrl <= wd[CTRL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baudCnt  <= '0;
      frameDiv <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else if (pop) begin
      state    <= START;
      tx       <= 1'b0;
      frameDiv <= divisor;
      baudCnt  <= divisor;
      shiftReg <= fifoMem[rdPtr];
`ifdef UART_TX_PARITY_EN
      parityBit <= (^fifoMem[rdPtr]) ^ ctrl[2];
`endif
    end else begin
      case (state)
        IDLE: tx <= 1'b1;
        START:
          if (baudCnt == 16'd0) begin
            state    <= DATA;
            tx       <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
            baudCnt  <= frameDiv;
          end else baudCnt <= baudCnt - 16'd1;
        DATA:
          if (baudCnt == 16'd0) begin
            baudCnt <= frameDiv;
            if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parityBit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              tx       <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end else baudCnt <= baudCnt - 16'd1;
`ifdef UART_TX_PARITY_EN
        PARITY:
          if (baudCnt == 16'd0) begin
            state   <= STOP;
            tx      <= 1'b1;
            baudCnt <= frameDiv;
          end else baudCnt <= baudCnt - 16'd1;
`endif
        STOP:
          if (baudCnt == 16'd0) begin
            state <= IDLE;
            tx    <= 1'b1;
          end else baudCnt <= baudCnt - 16'd1;
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    sizeMask = (memType[1:0] == 2'b00) ? 16'h00FF : 16'hFFFF;
    regVal   = '0;
    case (regSel)
      REG_STATUS:  regVal[8:0]        = {5'(count), ovf, busy, fifoEmpty, fifoFull};
      REG_DIVISOR: regVal[15:0]       = divisor;
      REG_CTRL:    regVal[CTRL_W-1:0] = ctrl;
      default:     ;
    endcase
    case (memType)
      3'b000:  sized = {{56{regVal[7]}},  regVal[7:0]};
      3'b001:  sized = {{48{regVal[15]}}, regVal[15:0]};
      3'b010:  sized = {{32{regVal[31]}}, regVal[31:0]};
      3'b100:  sized = {56'd0, regVal[7:0]};
      3'b101:  sized = {48'd0, regVal[15:0]};
      3'b110:  sized = {32'd0, regVal[31:0]};
      default: sized = regVal;
    endcase
    rd = (sel & ~we) ? sized : 64'd0;
  end

  logic unusedBits;
  assign unusedBits = ^{addr[63:5], addr[2:0], wd[63:16]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based register/line model checked every cycle, plus literal vectors.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_mmio_uart_tx;
  localparam int DEPTH = 8;
  localparam logic [63:0] A_TX = 64'h0, A_STATUS = 64'h8, A_DIV = 64'h10, A_CTRL = 64'h18;
  localparam logic [2:0] MT_B = 3'd0, MT_H = 3'd1, MT_W = 3'd2, MT_D = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4, MT_HU = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] CTRL_BITS = 3'b111;
`else
  localparam logic [2:0] CTRL_BITS = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        reset, sel, we;
  logic [2:0]  memType;
  logic [63:0] addr, wd, rd;
  logic        tx, irq;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd867)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .memType(memType),
    .addr(addr), .wd(wd), .rd(rd), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: FIFO as a queue, the line as a queue of per-clock levels.
  byte unsigned mFifo[$];
  bit           mTxQ[$];
  logic [15:0]  mDiv;
  logic [2:0]   mCtrl;
  bit           mOvf, mTx, mBusy;
  bit           modelValid = 1'b0;

  task automatic queueFrame(input byte unsigned b, input logic [15:0] div);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^b) ^ mCtrl[2]);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (int'(div) + 1) mTxQ.push_back(bits[k]);
  endtask

  always @(posedge clk) begin
    bit popNow;
    logic [15:0] m;
    if (reset) begin
      mFifo.delete();
      mTxQ.delete();
      mOvf = 1'b0; mDiv = 16'd867; mCtrl = 3'd0;
      mTx = 1'b1; mBusy = 1'b0; modelValid = 1'b1;
    end else if (modelValid) begin
      popNow = mCtrl[0] && mFifo.size() != 0 && mTxQ.size() == 0;
      if (popNow) queueFrame(mFifo.pop_front(), mDiv);
      if (sel && we) begin
        m = (memType[1:0] == 2'b00) ? 16'h00FF : 16'hFFFF;
        case (addr[4:3])
          2'd0: if (mFifo.size() < DEPTH) mFifo.push_back(wd[7:0]); else mOvf = 1'b1;
          2'd1: mOvf = 1'b0;
          2'd2: mDiv = (mDiv & ~m) | (wd[15:0] & m);
          default: mCtrl = wd[2:0] & CTRL_BITS;
        endcase
      end
      if (mTxQ.size() != 0) begin
        mTx = mTxQ.pop_front();
        mBusy = 1'b1;
      end else begin
        mTx = 1'b1;
        mBusy = 1'b0;
      end
    end
  end

  function automatic logic [63:0] modelRd();
    logic [63:0] raw;
    int n;
    n = mFifo.size();
    raw = 64'd0;
    case (addr[4:3])
      2'd1: raw = 64'(n * 16 + int'(mOvf) * 8 + int'(mBusy) * 4 + (n == 0 ? 2 : 0) + (n == DEPTH ? 1 : 0));
      2'd2: raw = 64'(mDiv);
      2'd3: raw = 64'(mCtrl);
      default: raw = 64'd0;
    endcase
    if (!sel || we) return 64'd0;
    case (memType)
      3'd0: return 64'($signed(raw[7:0]));
      3'd1: return 64'($signed(raw[15:0]));
      3'd2: return 64'($signed(raw[31:0]));
      3'd4: return 64'(raw[7:0]);
      3'd5: return 64'(raw[15:0]);
      3'd6: return 64'(raw[31:0]);
      default: return raw;
    endcase
  endfunction

  always @(negedge clk) begin
    if (modelValid) begin
      check("line tx", 64'(tx), 64'(mTx));
      check("irq", 64'(irq), 64'(mCtrl[1] && mFifo.size() == 0 && !mBusy));
      check("rd", rd, modelRd());
    end
  end

  // Stimulus helpers: each starts and ends 1 time unit after a rising edge.
  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [2:0] mt, input logic [63:0] d);
    sel = 1'b1; we = 1'b1; addr = a; memType = mt; wd = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; addr = 64'd0; memType = 3'd0; wd = 64'd0;
  endtask

  task automatic rdChk(input string name, input logic [63:0] a, input logic [2:0] mt, input logic [63:0] exp);
    sel = 1'b1; we = 1'b0; addr = a; memType = mt;
    @(negedge clk);
    check(name, rd, exp);
    @(posedge clk); #1;
    sel = 1'b0; addr = 64'd0; memType = 3'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  bit capTx[0:99], capBusy[0:99], capIrq[0:99];

  task automatic capture(input int n);
    sel = 1'b1; we = 1'b0; addr = A_STATUS; memType = MT_BU;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      capTx[i] = tx; capBusy[i] = rd[2]; capIrq[i] = irq;
    end
    @(posedge clk); #1;
    sel = 1'b0; addr = 64'd0; memType = 3'd0;
  endtask

  function automatic int busyCount(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(capBusy[i]);
    return c;
  endfunction

  logic [9:0] expFrame;

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; memType = 3'd0; addr = 64'd0; wd = 64'd0;
    @(posedge clk); #1;
    doReset();

    check("reset tx", 64'(tx), 64'd1);
    check("reset irq", 64'(irq), 64'd0);
    rdChk("reset STATUS", A_STATUS, MT_BU, 64'h2);
    rdChk("reset DIVISOR", A_DIV, MT_D, 64'd867);
    rdChk("reset CTRL", A_CTRL, MT_D, 64'd0);
    rdChk("TXDATA reads 0", A_TX, MT_D, 64'd0);

    // Size-masked DIVISOR writes and sign/zero-extended reads.
    wr(A_DIV, MT_D, 64'h1234_5678_9ABC_8000);
    rdChk("DIV lh sign", A_DIV, MT_H, 64'hFFFF_FFFF_FFFF_8000);
    rdChk("DIV lw", A_DIV, MT_W, 64'h8000);
    wr(A_DIV, MT_B, 64'hAB05);
    rdChk("DIV sb merge", A_DIV, MT_HU, 64'h8005);
    wr(A_DIV, MT_H, 64'hFFFF_0003);
    rdChk("DIV sh", A_DIV, MT_D, 64'h3);

    wr(A_CTRL, MT_D, 64'hFF);
    rdChk("CTRL readback", A_CTRL, MT_D, 64'(CTRL_BITS));
    check("irq idle empty", 64'(irq), 64'd1);
    wr(A_CTRL, MT_W, 64'h1);

    // Single 0xA5 frame at 4 clocks per bit.
    wr(A_TX, MT_B, 64'hA5);
    capture(44);
    expFrame = 10'b1101001010;
    check("A5 pre-start tx", 64'(capTx[0]), 64'd1);
    for (int i = 0; i < 40; i++) check($sformatf("A5 tx clk %0d", i), 64'(capTx[i+1]), 64'(expFrame[i/4]));
    check("A5 busy clocks", 64'(busyCount(44)), 64'd40);
    check("A5 idle after", 64'(capBusy[41]), 64'd0);
    rdChk("STATUS after A5", A_STATUS, MT_BU, 64'h2);

    // Back-to-back frames: second start bit right after first stop bit.
    wr(A_TX, MT_H, 64'h123C);
    wr(A_TX, MT_D, 64'hC3);
    capture(84);
    check("b2b stop bit", 64'(capTx[39]), 64'd1);
    check("b2b next start", 64'(capTx[40]), 64'd0);
    check("b2b busy clocks", 64'(busyCount(84)), 64'd80);
    check("b2b idle after", 64'(capBusy[80]), 64'd0);

    // Overflow with en=0.
    wr(A_CTRL, MT_B, 64'h0);
    for (int i = 0; i < 9; i++) wr(A_TX, MT_B, 64'(8'h10 + i));
    rdChk("full+ovf STATUS", A_STATUS, MT_BU, 64'h89);
    wr(A_STATUS, MT_W, 64'h0);
    rdChk("ovf cleared", A_STATUS, MT_BU, 64'h81);
    rdChk("lb STATUS", A_STATUS, MT_B, 64'hFFFF_FFFF_FFFF_FF81);
    rdChk("ld odd addr", 64'hFFFF_0000_0000_000D, MT_D, 64'h81);

    // Push and pop on the same clock while full.
    wr(A_CTRL, MT_B, 64'h1);
    wr(A_TX, MT_B, 64'h5A);
    rdChk("full push+pop", A_STATUS, MT_BU, 64'h85);
    wr(A_CTRL, MT_B, 64'h0);
    idle(50);
    rdChk("en cleared mid-frame", A_STATUS, MT_BU, 64'h81);

    // Reset in the middle of the data bits.
    wr(A_CTRL, MT_B, 64'h1);
    idle(10);
    check("mid-DATA tx low", 64'(tx), 64'd0);
    doReset();
    @(negedge clk);
    check("tx high after reset", 64'(tx), 64'd1);
    @(posedge clk); #1;
    rdChk("STATUS after reset", A_STATUS, MT_BU, 64'h2);
    rdChk("DIVISOR after reset", A_DIV, MT_D, 64'd867);

`ifdef UART_TX_PARITY_EN
    wr(A_DIV, MT_D, 64'h3);
    wr(A_CTRL, MT_B, 64'h3);
    wr(A_TX, MT_B, 64'h07);
    capture(50);
    check("parity bit", 64'(capTx[37]), 64'd1);
    check("parity stop", 64'(capTx[41]), 64'd1);
    check("parity busy clocks", 64'(busyCount(50)), 64'd44);
    check("irq low in stop", 64'(capIrq[44]), 64'd0);
    check("irq after stop", 64'(capIrq[45]), 64'd1);
`endif

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
